// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - instruction memory and decode handshake bundle for the fetch controller
interface fetch_controller_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_ack, mem_rdata, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_ack, mem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC owner and instruction fetch sequencer with wait-state and redirect handling
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    fetch_controller_if.master        bus,
    output logic [31:0]               pc,
    output logic [31:0]               fetch_count
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT_DEC} state_t;

    state_t      r_state,       w_state_nxt;
    logic [31:0] r_pc,          w_pc_nxt;
    logic [31:0] r_mem_addr,    w_mem_addr_nxt;
    logic        r_mem_req,     w_mem_req_nxt;
    logic [31:0] r_inst,        w_inst_nxt;
    logic [31:0] r_inst_pc,     w_inst_pc_nxt;
    logic        r_inst_valid,  w_inst_valid_nxt;
    logic [31:0] r_fetch_count, w_fetch_count_nxt;

    logic [31:0] w_target;
    logic [31:0] w_resume;
    logic        w_handshake;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_mem_addr    <= RESET_PC;
            r_mem_req     <= 1'b0;
            r_inst        <= 32'h0;
            r_inst_pc     <= 32'h0;
            r_inst_valid  <= 1'b0;
            r_fetch_count <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_inst        <= w_inst_nxt;
            r_inst_pc     <= w_inst_pc_nxt;
            r_inst_valid  <= w_inst_valid_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_mem_addr_nxt    = r_mem_addr;
        w_inst_nxt        = r_inst;
        w_inst_pc_nxt     = r_inst_pc;
        w_inst_valid_nxt  = r_inst_valid;
        w_fetch_count_nxt = r_fetch_count;
        w_target          = redirect_pc & ~32'h3;
        w_handshake       = r_inst_valid & bus.inst_ready;
        // A redirect in the same cycle always beats the stored pc as the restart address
        w_resume          = redirect_valid ? w_target : r_pc;

        if (redirect_valid)
            w_pc_nxt = w_target;

        case (r_state)
            IDLE: begin
                if (!stall) begin
                    w_mem_addr_nxt = w_resume;
                    w_state_nxt    = FETCH;
                end
            end
            FETCH: begin
                if (bus.mem_ack && !redirect_valid) begin
                    w_inst_nxt       = bus.mem_rdata;
                    w_inst_pc_nxt    = r_mem_addr;
                    w_inst_valid_nxt = 1'b1;
                    w_pc_nxt         = r_mem_addr + PC_INC;
                    w_state_nxt      = WAIT_DEC;
                end else if (bus.mem_ack) begin
                    w_mem_addr_nxt = stall ? r_mem_addr : w_resume;
                    w_state_nxt    = stall ? IDLE : FETCH;
                end else if (redirect_valid) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.mem_ack) begin
                    w_mem_addr_nxt = stall ? r_mem_addr : w_resume;
                    w_state_nxt    = stall ? IDLE : FETCH;
                end
            end
            WAIT_DEC: begin
                if (w_handshake)
                    w_fetch_count_nxt = r_fetch_count + 32'd1;
                if (w_handshake || redirect_valid) begin
                    w_inst_valid_nxt = 1'b0;
                    w_mem_addr_nxt   = stall ? r_mem_addr : w_resume;
                    w_state_nxt      = stall ? IDLE : FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_mem_req_nxt = (w_state_nxt == FETCH) || (w_state_nxt == DRAIN);
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.inst_valid = r_inst_valid;
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign pc             = r_pc;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed self-checking bench for fetch_controller
module tb_fetch_controller;
    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] fetch_count;

    int   checks;
    int   errors;
    int   ws;
    int   wcnt;
    logic req_s;

    fetch_controller_if bus ();

    fetch_controller #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (32'd4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .pc             (pc),
        .fetch_count    (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: memory model answers after ws wait cycles with addr ^ DEAD0000
    task automatic step();
        @(negedge clk);
        req_s = bus.mem_req;
        bus.mem_ack   = req_s && (wcnt >= ws);
        bus.mem_rdata = bus.mem_ack ? (bus.mem_addr ^ 32'hDEAD_0000) : 32'h0;
        @(posedge clk);
        if (req_s && bus.mem_ack) wcnt = 0;
        else if (req_s) wcnt++;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ws = 0;
        wcnt = 0;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.inst_ready = 1'b1;

        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        rst = 1'b1;

        // zero-wait streaming: request on odd cycles, delivery on even cycles
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k % 2 == 1) begin
                chk("t1_req", {31'h0, bus.mem_req}, 32'h1);
                chk("t1_addr", bus.mem_addr, (k - 1) * 2);
                chk("t1_count", fetch_count, (k - 1) / 2);
                chk("t1_valid_lo", {31'h0, bus.inst_valid}, 32'h0);
            end else begin
                chk("t1_valid_hi", {31'h0, bus.inst_valid}, 32'h1);
                chk("t1_inst_pc", bus.inst_pc, (k - 2) * 2);
                chk("t1_inst", bus.inst, ((k - 2) * 2) ^ 32'hDEAD_0000);
                chk("t1_req_lo", {31'h0, bus.mem_req}, 32'h0);
            end
        end
        chk("t1_count4", fetch_count, 32'd4);

        // three wait states at 0x10
        ws = 3;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_req", {31'h0, bus.mem_req}, 32'h1);
            chk("t2_addr", bus.mem_addr, 32'h10);
            chk("t2_valid", {31'h0, bus.inst_valid}, 32'h0);
        end
        step();
        chk("t2_valid_hi", {31'h0, bus.inst_valid}, 32'h1);
        chk("t2_inst", bus.inst, 32'hDEAD_0010);
        chk("t2_inst_pc", bus.inst_pc, 32'h10);
        chk("t2_pc", pc, 32'h14);
        chk("t2_req_lo", {31'h0, bus.mem_req}, 32'h0);

        // redirect coinciding with a handshake still counts the instruction
        redirect_valid = 1'b1;
        redirect_pc = 32'h8;
        step();
        redirect_valid = 1'b0;
        chk("hsr_count", fetch_count, 32'd5);
        chk("hsr_addr", bus.mem_addr, 32'h8);
        chk("hsr_pc", pc, 32'h8);
        chk("hsr_valid", {31'h0, bus.inst_valid}, 32'h0);

        // redirect during the 2nd wait cycle of the fetch at 0x8
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect_valid = 1'b0;
        chk("t3_pc", pc, 32'h200);
        chk("t3_req", {31'h0, bus.mem_req}, 32'h1);
        chk("t3_addr_hold", bus.mem_addr, 32'h8);
        step();
        chk("t3_addr_hold2", bus.mem_addr, 32'h8);
        chk("t3_valid", {31'h0, bus.inst_valid}, 32'h0);
        step();
        chk("t3_next_addr", bus.mem_addr, 32'h200);
        chk("t3_next_req", {31'h0, bus.mem_req}, 32'h1);
        chk("t3_valid_lo", {31'h0, bus.inst_valid}, 32'h0);
        chk("t3_count", fetch_count, 32'd5);

        // decode back-pressure, then flush by redirect
        ws = 0;
        bus.inst_ready = 1'b0;
        step();
        chk("t4_valid", {31'h0, bus.inst_valid}, 32'h1);
        chk("t4_pc", pc, 32'h204);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_hold_inst", bus.inst, 32'hDEAD_0200);
            chk("t4_hold_inst_pc", bus.inst_pc, 32'h200);
            chk("t4_hold_valid", {31'h0, bus.inst_valid}, 32'h1);
            chk("t4_hold_req", {31'h0, bus.mem_req}, 32'h0);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk("t4_flush_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("t4_flush_count", fetch_count, 32'd5);
        chk("t4_flush_addr", bus.mem_addr, 32'h40);
        chk("t4_flush_req", {31'h0, bus.mem_req}, 32'h1);

        // stall: in-flight request completes, no new requests until release
        stall = 1'b1;
        bus.inst_ready = 1'b1;
        step();
        chk("t5_inflight_valid", {31'h0, bus.inst_valid}, 32'h1);
        chk("t5_inflight_pc", bus.inst_pc, 32'h40);
        chk("t5_inflight_req", {31'h0, bus.mem_req}, 32'h0);
        step();
        chk("t5_hs_count", fetch_count, 32'd6);
        chk("t5_hs_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("t5_hs_req", {31'h0, bus.mem_req}, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t5_idle_req", {31'h0, bus.mem_req}, 32'h0);
        end
        stall = 1'b0;
        step();
        chk("t5_rel_req", {31'h0, bus.mem_req}, 32'h1);
        chk("t5_rel_addr", bus.mem_addr, 32'h44);

        // wrap past the top of the address space
        step();
        chk("t6_inst_pc", bus.inst_pc, 32'h44);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        chk("t6_top_addr", bus.mem_addr, 32'hFFFF_FFFC);
        chk("t6_top_count", fetch_count, 32'd7);
        step();
        chk("t6_top_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
        chk("t6_wrap_pc", pc, 32'h0);
        step();
        chk("t6_wrap_addr", bus.mem_addr, 32'h0);
        chk("t6_wrap_req", {31'h0, bus.mem_req}, 32'h1);
        chk("t6_wrap_count", fetch_count, 32'd8);

        // asynchronous reset in the middle of a waited request
        ws = 3;
        step();
        chk("t6_mid_req", {31'h0, bus.mem_req}, 32'h1);
        rst = 1'b0;
        #1;
        chk("t6_ar_req", {31'h0, bus.mem_req}, 32'h0);
        chk("t6_ar_addr", bus.mem_addr, 32'h0);
        chk("t6_ar_pc", pc, 32'h0);
        chk("t6_ar_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("t6_ar_inst", bus.inst, 32'h0);
        chk("t6_ar_inst_pc", bus.inst_pc, 32'h0);
        chk("t6_ar_count", fetch_count, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences instruction fetch for the single-cycle/multicycle MIPS core.
- Owns the PC.
- Issues requests to the instruction memory over a req/ack handshake that tolerates wait states.
- Buffers one fetched word for decode behind a valid/ready handshake.
- Handles branch/jump redirects, including a redirect that arrives while a memory access is in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
PC_INC, 4, byte increment per sequential fetch

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
stall  input  1  1 = do not start a new memory request
redirect_valid  input  1  1 = load redirect_pc as next fetch address
redirect_pc  input  32  branch/jump target; bits [1:0] ignored (forced 0)
mem_req  output  1  instruction memory request
mem_addr  output  32  instruction memory byte address
mem_ack  input  1  memory returns mem_rdata this cycle
mem_rdata  input  32  instruction word from memory
inst_valid  output  1  inst/inst_pc hold a valid instruction
inst_ready  input  1  decode accepts the instruction
inst  output  32  buffered instruction word
inst_pc  output  32  address the buffered instruction was fetched from
pc  output  32  next sequential fetch address
fetch_count  output  32  number of instructions delivered to decode (handshakes)

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, mem_addr=RESET_PC, mem_req=0, inst_valid=0, inst=0, inst_pc=0, fetch_count=0. Release is sampled on the next rising clk.
- All outputs are registered. mem_req=1 exactly while state is FETCH or DRAIN.
- Memory protocol:
  - mem_addr stays stable while mem_req=1 until mem_ack is sampled high.
  - mem_ack is legal in the first request cycle (zero-wait memory).
  - A request is never withdrawn before its ack.
- States:
  - IDLE:
    - redirect_valid → pc<=redirect_pc&~3.
    - !stall → mem_addr<=(redirect_valid ? redirect target : pc), go FETCH.
    - Otherwise stay in IDLE.
  - FETCH:
    - mem_ack & !redirect_valid → inst<=mem_rdata, inst_pc<=mem_addr, inst_valid<=1, pc<=mem_addr+PC_INC, go WAIT_DEC.
    - mem_ack & redirect_valid → discard data, pc<=target; if !stall go FETCH with mem_addr<=target, else go IDLE.
    - !mem_ack & redirect_valid → pc<=target, go DRAIN.
    - !mem_ack & !redirect_valid → hold.
  - DRAIN (stale request outstanding):
    - Keep mem_req/mem_addr until mem_ack, then discard mem_rdata.
    - On that ack: if !stall go FETCH with mem_addr<=pc, else go IDLE.
    - A further redirect in DRAIN only updates pc (latest wins).
  - WAIT_DEC:
    - inst_valid & inst_ready → handshake: fetch_count+=1, inst_valid<=0.
    - redirect_valid with no handshake → inst_valid<=0 (flush), no count; pc<=target.
    - redirect_valid with handshake in the same cycle → the instruction counts as delivered, pc<=target.
    - On handshake or redirect: next fetch address = target if redirect else pc. If !stall go FETCH with mem_addr<=that address, else go IDLE.
    - Otherwise hold; inst/inst_pc stay stable.
- Priority: reset > redirect > ack/handshake > stall.
- Throughput: with zero-wait memory and inst_ready=1, one instruction per 2 cycles.
- Arithmetic: pc and mem_addr increments wrap modulo 2^32 (0xFFFF_FFFC+4 → 0). fetch_count wraps at 2^32.
- stall never aborts an outstanding request or clears inst_valid.
- Reset asserted mid-request drops mem_req immediately; memory must tolerate the abort.

Test Plan:
1. Reset then run, zero-wait memory (mem_ack same cycle as req), inst_ready=1 → mem_addr sequence 0,4,8,C; inst_pc matches mem_addr; inst_valid pulses every 2nd cycle; fetch_count=4 after 8 cycles.
2. Memory with 3 wait states, fetch at 0x10 → mem_req held 4 cycles with mem_addr=0x10; inst=mem_rdata; inst_pc=0x10; pc=0x14.
3. Redirect to 0x203 during the 2nd wait cycle of a fetch at 0x8 → pc=0x200; mem_addr stays 0x8 until ack; data discarded (inst_valid stays 0); next request at 0x200.
4. inst_ready=0 for 5 cycles with inst_valid=1 → inst/inst_pc unchanged, mem_req=0. Then redirect to 0x40 with inst_ready=0 → inst_valid drops, fetch_count unchanged, next mem_addr=0x40.
5. stall=1 held from IDLE and while WAIT_DEC completes → no mem_req. An in-flight request still completes on ack. Release stall → request at the correct pc next cycle.
6. Redirect to 0xFFFF_FFFC, then sequential fetch → next mem_addr=0x0000_0000. Assert rst mid-request → all outputs return to reset values asynchronously.
